// File: rtl/cdm_bus_unit_if.sv
// cdm_bus_unit_if: CPU request/response and byte-lane memory beat signals of the cdm bus unit.
// slave is the bus unit's view; master is the view of the CPU and memory around it.
interface cdm_bus_unit_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_sext;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic                  resp_valid;
    logic [DATA_W-1:0]     resp_rdata;
    logic                  bus_err;
    logic                  stall;
    logic                  mem_valid;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W/8-1:0]   mem_be;
    logic                  mem_we;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_ready;

    modport slave (
        input  req_valid, req_write, req_size, req_sext, req_addr, req_wdata, mem_rdata, mem_ready,
        output req_ready, resp_valid, resp_rdata, bus_err, stall,
        output mem_valid, mem_addr, mem_be, mem_we, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_size, req_sext, req_addr, req_wdata, mem_rdata, mem_ready,
        input  req_ready, resp_valid, resp_rdata, bus_err, stall,
        input  mem_valid, mem_addr, mem_be, mem_we, mem_wdata
    );
endinterface

// File: rtl/cdm_bus_unit.sv
// cdm_bus_unit: load/store bus unit between the cdm datapath and byte-lane memory.
// Takes one byte/half/word request, splits accesses crossing a DATA_W boundary into two beats,
// merges and zero/sign-extends read data, and flags illegal sizes as bus errors.
// Optional feature: define BUS_TIMEOUT_EN to abort a beat after TIMEOUT_CYCLES wait cycles.
module cdm_bus_unit #(
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input logic           clk,
    input logic           reset_n,
    cdm_bus_unit_if.slave bus
);
    localparam int unsigned NB   = DATA_W / 8;
    localparam int unsigned OFFW = $clog2(NB);

    typedef enum logic [1:0] {StIdle, StBeat0, StBeat1, StDone} state_e;

    // Byte mask of an access of the given size, LSB-justified.
    function automatic logic [NB-1:0] size_mask(input logic [1:0] size);
        case (size)
            2'd0:    return NB'(1);
            2'd1:    return NB'(3);
            default: return NB'(15);
        endcase
    endfunction

    // Expand a byte mask into a bit mask.
    function automatic logic [DATA_W-1:0] lanes(input logic [NB-1:0] be);
        logic [DATA_W-1:0] m;
        for (int i = 0; i < NB; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

    state_e              r_state;
    logic [ADDR_W-1:0]   r_addr;     // aligned beat0 address
    logic [OFFW-1:0]     r_off;
    logic [1:0]          r_size;
    logic                r_write;
    logic                r_sext;
    logic                r_split;
    logic [NB-1:0]       r_be1;
    logic [DATA_W-1:0]   r_wdata1;
    logic [DATA_W-1:0]   r_rbuf0;    // lanes captured in beat0 of a split read
    logic                r_mem_valid;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [NB-1:0]       r_mem_be;
    logic                r_mem_we;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_resp_valid;
    logic [DATA_W-1:0]   r_resp_rdata;
    logic                r_bus_err;

    logic [OFFW-1:0]     w_off;
    logic [ADDR_W-1:0]   w_aligned;
    logic                w_illegal;
    logic [2*NB-1:0]     w_be_full;
    logic [2*DATA_W-1:0] w_wd_full;
    logic [DATA_W-1:0]   w_rd_masked;
    logic [2*DATA_W-1:0] w_rbuf;
    logic [DATA_W-1:0]   w_raw;
    logic                w_sbit;
    logic [DATA_W-1:0]   w_rresult;
    logic                w_timeout;

    // Decode the incoming request into both beats' byte enables and lane-positioned write data.
    always_comb begin
        w_off     = bus.req_addr[OFFW-1:0];
        w_aligned = {bus.req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
        w_illegal = (bus.req_size == 2'd3) || ((bus.req_size == 2'd2) && (DATA_W < 32));
        w_be_full = {{NB{1'b0}}, size_mask(bus.req_size)} << w_off;
        w_wd_full = {{DATA_W{1'b0}}, bus.req_wdata & lanes(size_mask(bus.req_size))}
                    << {w_off, 3'b000};
    end

    // Assemble the read result from captured lanes plus the beat completing this cycle.
    always_comb begin
        w_rd_masked = bus.mem_rdata & lanes(r_mem_be);
        w_rbuf      = (r_state == StBeat1) ? {w_rd_masked, r_rbuf0}
                                           : {{DATA_W{1'b0}}, w_rd_masked};
        w_raw       = DATA_W'(w_rbuf >> {r_off, 3'b000}) & lanes(size_mask(r_size));
        case (r_size)
            2'd0:    w_sbit = w_raw[7];
            2'd1:    w_sbit = w_raw[15];
            default: w_sbit = w_raw[DATA_W-1];
        endcase
        w_rresult   = (r_sext && w_sbit) ? (w_raw | ~lanes(size_mask(r_size))) : w_raw;
    end

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_wait;

    // Count wait cycles of the current beat; a completed beat or an idle bus clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait <= '0;
        end else if (!r_mem_valid || bus.mem_ready || w_timeout) begin
            r_wait <= '0;
        end else begin
            r_wait <= r_wait + TW'(1);
        end
    end

    assign w_timeout = r_mem_valid && !bus.mem_ready && (r_wait == TW'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // Transaction FSM with registered memory-side and response outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= StIdle;
            r_addr       <= '0;
            r_off        <= '0;
            r_size       <= '0;
            r_write      <= 1'b0;
            r_sext       <= 1'b0;
            r_split      <= 1'b0;
            r_be1        <= '0;
            r_wdata1     <= '0;
            r_rbuf0      <= '0;
            r_mem_valid  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_be     <= '0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_bus_err    <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (bus.req_valid) begin
                        r_addr   <= w_aligned;
                        r_off    <= w_off;
                        r_size   <= bus.req_size;
                        r_write  <= bus.req_write;
                        r_sext   <= bus.req_sext;
                        r_split  <= |w_be_full[2*NB-1:NB];
                        r_be1    <= w_be_full[2*NB-1:NB];
                        r_wdata1 <= w_wd_full[2*DATA_W-1:DATA_W];
                        r_rbuf0  <= '0;
                        if (w_illegal) begin
                            r_state      <= StDone;
                            r_resp_valid <= 1'b1;
                            r_bus_err    <= 1'b1;
                        end else begin
                            r_state     <= StBeat0;
                            r_mem_valid <= 1'b1;
                            r_mem_addr  <= w_aligned;
                            r_mem_be    <= w_be_full[NB-1:0];
                            r_mem_we    <= bus.req_write;
                            r_mem_wdata <= w_wd_full[DATA_W-1:0];
                        end
                    end
                end
                StBeat0, StBeat1: begin
                    if (bus.mem_ready) begin
                        if ((r_state == StBeat0) && r_split) begin
                            r_state     <= StBeat1;
                            r_rbuf0     <= w_rd_masked;
                            r_mem_addr  <= r_addr + ADDR_W'(NB);
                            r_mem_be    <= r_be1;
                            r_mem_wdata <= r_wdata1;
                        end else begin
                            r_state      <= StDone;
                            r_mem_valid  <= 1'b0;
                            r_mem_addr   <= '0;
                            r_mem_be     <= '0;
                            r_mem_we     <= 1'b0;
                            r_mem_wdata  <= '0;
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= r_write ? '0 : w_rresult;
                        end
                    end else if (w_timeout) begin
                        // Abandon the transaction, including any remaining beat.
                        r_state      <= StDone;
                        r_mem_valid  <= 1'b0;
                        r_mem_addr   <= '0;
                        r_mem_be     <= '0;
                        r_mem_we     <= 1'b0;
                        r_mem_wdata  <= '0;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= '0;
                        r_bus_err    <= 1'b1;
                    end
                end
                StDone: begin
                    r_state      <= StIdle;
                    r_resp_rdata <= '0;
                    r_bus_err    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = (r_state == StIdle);
    assign bus.stall      = (r_state != StIdle);
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.bus_err    = r_bus_err;
    assign bus.mem_valid  = r_mem_valid;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_be     = r_mem_be;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_wdata  = r_mem_wdata;
endmodule

// File: tb/tb_cdm_bus_unit.sv
// tb_cdm_bus_unit: directed vectors for cdm_bus_unit at DATA_W=16 and DATA_W=32.
// Honours BUS_TIMEOUT_EN the same way the design does.
module tb_cdm_bus_unit;
    logic clk = 1'b0;
    logic reset_n;
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    cdm_bus_unit_if #(.ADDR_W(16), .DATA_W(16)) b16 ();
    cdm_bus_unit_if #(.ADDR_W(16), .DATA_W(32)) b32 ();

    cdm_bus_unit #(.ADDR_W(16), .DATA_W(16), .TIMEOUT_CYCLES(15)) u_dut16 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b16.slave)
    );

    cdm_bus_unit #(.ADDR_W(16), .DATA_W(32), .TIMEOUT_CYCLES(15)) u_dut32 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b32.slave)
    );

    // Results of the last transaction.
    int          t_beats;
    int          t_lat;
    logic [15:0] t_addr [2];
    logic [3:0]  t_be   [2];
    logic [31:0] t_wd   [2];
    logic        t_we   [2];
    logic [31:0] t_rdata;
    logic        t_err;
    logic        t_stall;
    logic        t_seen;
    logic        t_resp_after;
    logic        t_ready_after;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

    task automatic drive_req(input bit w32, input bit v, input bit wr, input logic [1:0] size,
                             input bit sext, input logic [15:0] addr, input logic [31:0] wdata);
        b16.req_valid = v && !w32;
        b32.req_valid = v && w32;
        b16.req_write = wr;
        b32.req_write = wr;
        b16.req_size  = size;
        b32.req_size  = size;
        b16.req_sext  = sext;
        b32.req_sext  = sext;
        b16.req_addr  = addr;
        b32.req_addr  = addr;
        b16.req_wdata = wdata[15:0];
        b32.req_wdata = wdata;
    endtask

    task automatic set_mem(input bit w32, input bit rdy, input logic [31:0] rd);
        b16.mem_ready = rdy && !w32;
        b32.mem_ready = rdy && w32;
        b16.mem_rdata = rd[15:0];
        b32.mem_rdata = rd;
    endtask

    // Issue one request and act as memory: every beat waits 'waits' cycles, then completes
    // with rd0 (first beat) or rd1 (second beat). Latency counts the accept cycle as 1.
    task automatic xact(input bit w32, input bit wr, input logic [1:0] size, input bit sext,
                        input logic [15:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rd0, input logic [31:0] rd1, input int waits);
        int c;
        int wc;
        t_beats = 0;
        t_lat   = 0;
        t_seen  = 1'b0;
        t_rdata = '0;
        t_err   = 1'b0;
        t_stall = 1'b0;
        for (int i = 0; i < 2; i++) begin
            t_addr[i] = '0;
            t_be[i]   = '0;
            t_wd[i]   = '0;
            t_we[i]   = 1'b0;
        end
        wc = 0;
        drive_req(w32, 1'b1, wr, size, sext, addr, wdata);
        @(negedge clk);
        check_eq("req_ready before accept", w32 ? b32.req_ready : b16.req_ready, 1);
        @(posedge clk);
        #1;
        drive_req(w32, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 32'h0);
        c = 2;
        while (!t_seen && c < 40) begin
            @(negedge clk);
            if (c == 2) t_stall = w32 ? b32.stall : b16.stall;
            if (w32 ? b32.resp_valid : b16.resp_valid) begin
                t_seen  = 1'b1;
                t_lat   = c;
                t_rdata = w32 ? b32.resp_rdata : {16'h0, b16.resp_rdata};
                t_err   = w32 ? b32.bus_err : b16.bus_err;
                set_mem(w32, 1'b0, 32'h0);
            end else if (w32 ? b32.mem_valid : b16.mem_valid) begin
                if (wc < waits) begin
                    wc++;
                    set_mem(w32, 1'b0, 32'h0);
                end else begin
                    if (t_beats < 2) begin
                        t_addr[t_beats] = w32 ? b32.mem_addr : b16.mem_addr;
                        t_be[t_beats]   = w32 ? b32.mem_be : {2'b00, b16.mem_be};
                        t_wd[t_beats]   = w32 ? b32.mem_wdata : {16'h0, b16.mem_wdata};
                        t_we[t_beats]   = w32 ? b32.mem_we : b16.mem_we;
                    end
                    set_mem(w32, 1'b1, (t_beats == 0) ? rd0 : rd1);
                    t_beats++;
                    wc = 0;
                end
            end else begin
                set_mem(w32, 1'b0, 32'h0);
            end
            @(posedge clk);
            #1;
            c++;
        end
        set_mem(w32, 1'b0, 32'h0);
        check_eq("resp_valid seen", t_seen, 1);
        @(negedge clk);
        t_resp_after  = w32 ? b32.resp_valid : b16.resp_valid;
        t_ready_after = w32 ? b32.req_ready : b16.req_ready;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic seen;
        reset_n = 1'b0;
        drive_req(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 32'h0);
        set_mem(1'b0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);

        // Reset state
        check_eq("rst req_ready", b16.req_ready, 1);
        check_eq("rst stall", b16.stall, 0);
        check_eq("rst mem_valid", b16.mem_valid, 0);
        check_eq("rst resp_valid", b16.resp_valid, 0);
        check_eq("rst bus_err", b16.bus_err, 0);
        check_eq("rst mem_we", b16.mem_we, 0);
        check_eq("rst mem_addr", b16.mem_addr, 0);
        check_eq("rst mem_be", b16.mem_be, 0);
        check_eq("rst mem_wdata", b16.mem_wdata, 0);
        check_eq("rst resp_rdata", b16.resp_rdata, 0);
        check_eq("rst req_ready 32", b32.req_ready, 1);
        check_eq("rst mem_valid 32", b32.mem_valid, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 16: aligned half read
        xact(1'b0, 1'b0, 2'd1, 1'b0, 16'h0010, 32'h0, 32'hBEEF, 32'h0, 0);
        check_eq("h10 beats", t_beats, 1);
        check_eq("h10 addr0", t_addr[0], 16'h0010);
        check_eq("h10 be0", t_be[0], 4'b0011);
        check_eq("h10 we0", t_we[0], 0);
        check_eq("h10 rdata", t_rdata, 32'hBEEF);
        check_eq("h10 err", t_err, 0);
        check_eq("h10 latency", t_lat, 3);
        check_eq("h10 stall", t_stall, 1);
        check_eq("h10 resp one cycle", t_resp_after, 0);
        check_eq("h10 ready after", t_ready_after, 1);

        // 16: split half read
        xact(1'b0, 1'b0, 2'd1, 1'b0, 16'h0011, 32'h0, 32'hAA00, 32'h00BB, 0);
        check_eq("h11 beats", t_beats, 2);
        check_eq("h11 addr0", t_addr[0], 16'h0010);
        check_eq("h11 be0", t_be[0], 4'b0010);
        check_eq("h11 addr1", t_addr[1], 16'h0012);
        check_eq("h11 be1", t_be[1], 4'b0001);
        check_eq("h11 rdata", t_rdata, 32'hBBAA);
        check_eq("h11 latency", t_lat, 4);

        // 16: byte read, sign- and zero-extended
        xact(1'b0, 1'b0, 2'd0, 1'b1, 16'h0021, 32'h0, 32'h8000, 32'h0, 0);
        check_eq("b21s be0", t_be[0], 4'b0010);
        check_eq("b21s rdata", t_rdata, 32'hFF80);
        xact(1'b0, 1'b0, 2'd0, 1'b0, 16'h0021, 32'h0, 32'h8000, 32'h0, 0);
        check_eq("b21z rdata", t_rdata, 32'h0080);
        xact(1'b0, 1'b0, 2'd0, 1'b1, 16'h0040, 32'h0, 32'hFF7F, 32'h0, 0);
        check_eq("b40s be0", t_be[0], 4'b0001);
        check_eq("b40s rdata", t_rdata, 32'h007F);

        // 16: split half write, upper input bits must not leak
        xact(1'b0, 1'b1, 2'd1, 1'b0, 16'h0011, 32'hFFFF1234, 32'h0, 32'h0, 0);
        check_eq("wh11 beats", t_beats, 2);
        check_eq("wh11 we0", t_we[0], 1);
        check_eq("wh11 be0", t_be[0], 4'b0010);
        check_eq("wh11 wd0", t_wd[0] & lane_mask(t_be[0]), 32'h3400);
        check_eq("wh11 be1", t_be[1], 4'b0001);
        check_eq("wh11 wd1", t_wd[1] & lane_mask(t_be[1]), 32'h0012);
        check_eq("wh11 rdata", t_rdata, 32'h0);
        check_eq("wh11 err", t_err, 0);

        // 16: wait states
        xact(1'b0, 1'b0, 2'd1, 1'b0, 16'h0030, 32'h0, 32'h5A5A, 32'h0, 2);
        check_eq("w2 latency", t_lat, 5);
        check_eq("w2 rdata", t_rdata, 32'h5A5A);
        xact(1'b0, 1'b0, 2'd1, 1'b0, 16'h0035, 32'h0, 32'h7700, 32'h0066, 1);
        check_eq("w1 split latency", t_lat, 6);
        check_eq("w1 split rdata", t_rdata, 32'h6677);

        // 16: word size is illegal
        xact(1'b0, 1'b0, 2'd2, 1'b0, 16'h0050, 32'h0, 32'h1234, 32'h0, 0);
        check_eq("ill16 beats", t_beats, 0);
        check_eq("ill16 err", t_err, 1);
        check_eq("ill16 latency", t_lat, 2);
        check_eq("ill16 rdata", t_rdata, 32'h0);

        // 16: second beat address wraps
        xact(1'b0, 1'b0, 2'd1, 1'b0, 16'hFFFF, 32'h0, 32'h1100, 32'h0022, 0);
        check_eq("wrap addr0", t_addr[0], 16'hFFFE);
        check_eq("wrap addr1", t_addr[1], 16'h0000);
        check_eq("wrap rdata", t_rdata, 32'h2211);

        // 32: split word write
        xact(1'b1, 1'b1, 2'd2, 1'b0, 16'h0103, 32'h11223344, 32'h0, 32'h0, 0);
        check_eq("ww103 beats", t_beats, 2);
        check_eq("ww103 addr0", t_addr[0], 16'h0100);
        check_eq("ww103 be0", t_be[0], 4'b1000);
        check_eq("ww103 wd0", t_wd[0] & lane_mask(t_be[0]), 32'h44000000);
        check_eq("ww103 addr1", t_addr[1], 16'h0104);
        check_eq("ww103 be1", t_be[1], 4'b0111);
        check_eq("ww103 wd1", t_wd[1] & lane_mask(t_be[1]), 32'h00112233);
        check_eq("ww103 we1", t_we[1], 1);

        // 32: split word read, half read with sign, aligned word, illegal size
        xact(1'b1, 1'b0, 2'd2, 1'b1, 16'h0202, 32'h0, 32'hBBAA0000, 32'h0000DDCC, 0);
        check_eq("rw202 rdata", t_rdata, 32'hDDCCBBAA);
        check_eq("rw202 latency", t_lat, 4);
        xact(1'b1, 1'b0, 2'd1, 1'b1, 16'h0001, 32'h0, 32'h00F01200, 32'h0, 0);
        check_eq("rh1 be0", t_be[0], 4'b0110);
        check_eq("rh1 rdata", t_rdata, 32'hFFFFF012);
        xact(1'b1, 1'b0, 2'd2, 1'b0, 16'h0200, 32'h0, 32'hCAFEF00D, 32'h0, 0);
        check_eq("rw200 beats", t_beats, 1);
        check_eq("rw200 be0", t_be[0], 4'b1111);
        check_eq("rw200 rdata", t_rdata, 32'hCAFEF00D);
        xact(1'b1, 1'b0, 2'd3, 1'b0, 16'h0200, 32'h0, 32'h0, 32'h0, 0);
        check_eq("ill32 err", t_err, 1);
        check_eq("ill32 beats", t_beats, 0);

`ifdef BUS_TIMEOUT_EN
        // Memory never ready: 15 wait cycles then bus error
        xact(1'b0, 1'b0, 2'd1, 1'b0, 16'h0060, 32'h0, 32'h1234, 32'h0, 1000);
        check_eq("tmo beats", t_beats, 0);
        check_eq("tmo err", t_err, 1);
        check_eq("tmo latency", t_lat, 17);
        check_eq("tmo rdata", t_rdata, 32'h0);
`else
        // Long wait is tolerated without error
        xact(1'b0, 1'b0, 2'd1, 1'b0, 16'h0060, 32'h0, 32'h1234, 32'h0, 20);
        check_eq("longwait err", t_err, 0);
        check_eq("longwait latency", t_lat, 23);
        check_eq("longwait rdata", t_rdata, 32'h1234);
`endif

        // Reset during the second beat of a split read
        drive_req(1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 16'h0011, 32'h0);
        @(posedge clk);
        #1;
        drive_req(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 32'h0);
        @(negedge clk);
        check_eq("rstmid beat0 valid", b16.mem_valid, 1);
        set_mem(1'b0, 1'b1, 32'hAA00);
        @(posedge clk);
        #1;
        set_mem(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check_eq("rstmid beat1 valid", b16.mem_valid, 1);
        check_eq("rstmid beat1 addr", b16.mem_addr, 16'h0012);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("rstmid mem_valid async", b16.mem_valid, 0);
        check_eq("rstmid stall", b16.stall, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen = seen | b16.resp_valid;
        end
        check_eq("rstmid no resp", seen, 0);
        check_eq("rstmid req_ready", b16.req_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
